// File: rtl/pfrv_pkg.sv
// Shared types and constants for the pfr-v fetch path.
package pfrv_pkg;

  localparam int unsigned PcW    = 64;
  localparam int unsigned InstrW = 32;

  localparam logic [InstrW-1:0] NOP_INSTR = 32'h00000013;

  // One fetched instruction as handed to decode.
  typedef struct packed {
    logic [PcW-1:0]    pc;
    logic [InstrW-1:0] instr;
    logic              fault;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    RUN,
    HALT
  } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO between fetch and decode. The head always lives in slot 0,
// so the head output comes straight from a register. Flush beats push.
module fetch_buf
  import pfrv_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       push_i,
  input  entry_t     push_data_i,
  input  logic       pop_i,
  output logic [1:0] count_o,
  output entry_t     head_o
);

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic [1:0] count_q, count_d;
  logic [1:0] wr_idx;
  logic       do_push, do_pop;

  // Next-state: shift on pop, write behind the surviving entries on push.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    do_pop  = pop_i && (count_q != 2'd0);
    do_push = push_i && ((count_q != 2'd2) || do_pop);
    wr_idx  = count_q - (do_pop ? 2'd1 : 2'd0);
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      if (do_pop) begin
        mem_d[0] = mem_q[1];
      end
      if (do_push) begin
        mem_d[wr_idx[0]] = push_data_i;
      end
      count_d = count_q + (do_push ? 2'd1 : 2'd0) - (do_pop ? 2'd1 : 2'd0);
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[0];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, reads the combinational ROM and feeds
// {pc, instr, fault} to decode through a two-entry buffer. Misaligned or
// out-of-range fetches deliver a NOP marked as a fault and halt until redirect.
module ifetch_unit
  import pfrv_pkg::*;
#(
  parameter int unsigned     N        = 32,
  parameter int unsigned     ADDR_W   = 8,
  parameter int unsigned     PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = 64'h0,
  parameter logic [N-1:0]    NOP      = NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [N-1:0]      imem_q,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [N-1:0]      dec_instr,
  output logic [PC_W-1:0]   dec_pc,
  output logic              dec_fault
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [1:0]      count;
  logic            pop, push_ok, push, fault;
  fetch_entry_t    push_entry, head;

  assign imem_addr = pc_q[ADDR_W+1:2];
  assign pop       = dec_valid & dec_ready;
  assign push_ok   = (count < 2'd2) | pop;

  // Anything at or above 4*2^ADDR_W is unreachable; never wrap it into the ROM.
  assign fault = (pc_q[1:0] != 2'b00) || ((pc_q >> (ADDR_W + 2)) != '0);

  // Fetch control: redirect wins, otherwise push whenever there is room.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    if (redirect_valid) begin
      state_d = RUN;
      pc_d    = redirect_pc;
    end else if (state_q == RUN && push_ok) begin
      push = 1'b1;
      if (fault) begin
        state_d = HALT;
      end else begin
        pc_d = pc_q + PC_W'(4);
      end
    end
  end

  // Entry pushed this cycle; a faulting fetch substitutes the NOP word.
  always_comb begin
    push_entry.pc    = pc_q;
    push_entry.instr = fault ? NOP : imem_q;
    push_entry.fault = fault;
  end

  // PC and FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_buf #(
    .entry_t (fetch_entry_t)
  ) u_fetch_buf (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .count_o     (count),
    .head_o      (head)
  );

  assign dec_valid = (count != 2'd0);
  assign dec_pc    = head.pc;
  assign dec_instr = head.instr;
  assign dec_fault = head.fault;

endmodule
